// File: rtl/md_pkg.sv
// Shared definitions for the HI/LO multiply/divide sequencer: operation
// encodings, FSM state encoding and a small op-classification helper.
package md_pkg;

  localparam int unsigned MD_WORD_W = 32;

  // Operation codes as issued by the EX stage alongside start.
  typedef enum logic [1:0] {
    MD_MULT  = 2'd0,
    MD_MULTU = 2'd1,
    MD_DIV   = 2'd2,
    MD_DIVU  = 2'd3
  } md_op_e;

  // Sequencer states: waiting for an issue, or counting down an op.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_e;

  // True for either divide flavour; selects latency and div-by-zero handling.
  function automatic logic md_is_div(input md_op_e op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_ctrl_if.sv
// Bundle between the EX/ID stages and the multiply/divide sequencer.
// The pipeline side is the master; the sequencer is the slave.
interface muldiv_ctrl_if;
  import md_pkg::*;

  logic                 start;
  md_op_e               op;
  logic [MD_WORD_W-1:0] a;
  logic [MD_WORD_W-1:0] b;
  logic                 mt_we;
  logic                 mt_sel;
  logic                 md_use_D;
  logic                 busy;
  logic                 done;
  logic                 stall_md;
  logic [MD_WORD_W-1:0] hi;
  logic [MD_WORD_W-1:0] lo;
  logic                 div0;

  modport master (
    output start, op, a, b, mt_we, mt_sel, md_use_D,
    input  busy, done, stall_md, hi, lo, div0
  );

  modport slave (
    input  start, op, a, b, mt_we, mt_sel, md_use_D,
    output busy, done, stall_md, hi, lo, div0
  );

endinterface

// File: rtl/muldiv_core.sv
// Combinational arithmetic for the HI/LO unit: 64-bit signed/unsigned
// product, and quotient/remainder for signed/unsigned divide.
// Signed divide is done on magnitudes so that 0x80000000 / -1 falls out
// naturally as 0x80000000 rem 0 without relying on signed-overflow behaviour.
module muldiv_core
  import md_pkg::*;
(
  input  md_op_e               op,
  input  logic [MD_WORD_W-1:0] a,
  input  logic [MD_WORD_W-1:0] b,
  output logic [MD_WORD_W-1:0] res_hi,
  output logic [MD_WORD_W-1:0] res_lo,
  output logic                 div_by_zero
);

  logic [2*MD_WORD_W-1:0] prod_s;
  logic [2*MD_WORD_W-1:0] prod_u;
  logic                   a_neg;
  logic                   b_neg;
  logic [MD_WORD_W-1:0]   a_mag;
  logic [MD_WORD_W-1:0]   b_mag;
  logic [MD_WORD_W-1:0]   q_mag;
  logic [MD_WORD_W-1:0]   r_mag;
  logic [MD_WORD_W-1:0]   quot;
  logic [MD_WORD_W-1:0]   rem;

  // Products: sign-extend to 64 bits for MULT, zero-extend for MULTU.
  assign prod_s = $signed({{MD_WORD_W{a[MD_WORD_W-1]}}, a}) *
                  $signed({{MD_WORD_W{b[MD_WORD_W-1]}}, b});
  assign prod_u = {{MD_WORD_W{1'b0}}, a} * {{MD_WORD_W{1'b0}}, b};

  assign div_by_zero = (b == '0);

  // Magnitude divide, then restore signs: quotient truncates toward zero,
  // remainder takes the sign of the dividend.
  always_comb begin
    a_neg = (op == MD_DIV) && a[MD_WORD_W-1];
    b_neg = (op == MD_DIV) && b[MD_WORD_W-1];
    a_mag = a_neg ? (~a + 1'b1) : a;
    b_mag = b_neg ? (~b + 1'b1) : b;
    q_mag = '0;
    r_mag = '0;
    if (!div_by_zero) begin
      q_mag = a_mag / b_mag;
      r_mag = a_mag % b_mag;
    end
    quot = (a_neg ^ b_neg) ? (~q_mag + 1'b1) : q_mag;
    rem  = a_neg ? (~r_mag + 1'b1) : r_mag;
  end

  // Route the result for the selected operation onto {hi, lo}.
  always_comb begin
    res_hi = rem;
    res_lo = quot;
    case (op)
      MD_MULT:  {res_hi, res_lo} = prod_s;
      MD_MULTU: {res_hi, res_lo} = prod_u;
      default: begin
        res_hi = rem;
        res_lo = quot;
      end
    endcase
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// Multi-cycle sequencer for the HI/LO multiply/divide resource beside EX.
// Latches one op per start pulse, holds busy for a fixed op-dependent
// latency, then commits into HI/LO and pulses done. Also services mthi/mtlo
// writes while idle and raises the stall request for ID-stage HI/LO users.
module muldiv_ctrl
  import md_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10,
  parameter int unsigned CNT_W       = 4
) (
  input  logic            clk,
  input  logic            reset,
  muldiv_ctrl_if.slave    md
);

  localparam logic [CNT_W-1:0] MULT_LAST = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(DIV_CYCLES - 1);

  md_state_e            state_reg;
  md_state_e            state_next;
  logic [CNT_W-1:0]     cnt_reg;
  logic [CNT_W-1:0]     cnt_next;
  md_op_e               op_reg;
  logic [MD_WORD_W-1:0] a_reg;
  logic [MD_WORD_W-1:0] b_reg;
  logic [MD_WORD_W-1:0] hi_reg;
  logic [MD_WORD_W-1:0] lo_reg;
  logic                 div0_reg;
  logic                 done_reg;

  logic                 load_op;
  logic                 commit;
  logic                 mt_write;

  logic [MD_WORD_W-1:0] core_hi;
  logic [MD_WORD_W-1:0] core_lo;
  logic                 core_div0;

  // Single arithmetic instance, always fed from the latched operands so the
  // result is stable for the whole run regardless of EX-stage activity.
  muldiv_core u_core (
    .op          (op_reg),
    .a           (a_reg),
    .b           (b_reg),
    .res_hi      (core_hi),
    .res_lo      (core_lo),
    .div_by_zero (core_div0)
  );

  // State and countdown register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Next-state logic; start takes priority over an mt write in IDLE, and
  // both are ignored while an op is running.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    load_op    = 1'b0;
    commit     = 1'b0;
    mt_write   = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (md.start) begin
          load_op    = 1'b1;
          cnt_next   = md_is_div(md.op) ? DIV_LAST : MULT_LAST;
          state_next = ST_RUN;
        end else if (md.mt_we) begin
          mt_write = 1'b1;
        end
      end
      ST_RUN: begin
        if (cnt_reg == '0) begin
          commit     = 1'b1;
          state_next = ST_IDLE;
        end else begin
          cnt_next = cnt_reg - CNT_W'(1);
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Operand latches, HI/LO, sticky div0 and the done pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_reg   <= MD_MULT;
      a_reg    <= '0;
      b_reg    <= '0;
      hi_reg   <= '0;
      lo_reg   <= '0;
      div0_reg <= 1'b0;
      done_reg <= 1'b0;
    end else begin
      done_reg <= commit;
      if (load_op) begin
        op_reg   <= md.op;
        a_reg    <= md.a;
        b_reg    <= md.b;
        div0_reg <= 1'b0;
      end
      if (commit) begin
        if (md_is_div(op_reg) && core_div0) begin
          div0_reg <= 1'b1;
        end else begin
          hi_reg <= core_hi;
          lo_reg <= core_lo;
        end
      end
      if (mt_write) begin
        if (md.mt_sel) begin
          hi_reg <= md.a;
        end else begin
          lo_reg <= md.a;
        end
      end
    end
  end

  assign md.busy     = (state_reg == ST_RUN);
  assign md.done     = done_reg;
  assign md.stall_md = (md.start | md.busy) & md.md_use_D;
  assign md.hi       = hi_reg;
  assign md.lo       = lo_reg;
  assign md.div0     = div0_reg;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl: a table of single-op vectors plus
// hand-written sequences for reset, stall and collision corners.
module tb_muldiv_ctrl;
  import md_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  muldiv_ctrl_if md_bus ();

  muldiv_ctrl #(
    .MULT_CYCLES (5),
    .DIV_CYCLES  (10),
    .CNT_W       (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .md    (md_bus)
  );

  typedef struct {
    md_op_e      op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] pre_hi;
    logic [31:0] pre_lo;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    logic        exp_div0;
    int          exp_cycles;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mt_write(input logic sel, input logic [31:0] val);
    md_bus.mt_we  = 1'b1;
    md_bus.mt_sel = sel;
    md_bus.a      = val;
    tick();
    md_bus.mt_we  = 1'b0;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int n;
    mt_write(1'b1, v.pre_hi);
    mt_write(1'b0, v.pre_lo);
    md_bus.op    = v.op;
    md_bus.a     = v.a;
    md_bus.b     = v.b;
    md_bus.start = 1'b1;
    tick();
    md_bus.start = 1'b0;
    md_bus.a     = 32'hDEAD_BEEF;
    md_bus.b     = 32'h0000_0003;
    chk($sformatf("vec%0d hi_held", idx), md_bus.hi, v.pre_hi);
    chk($sformatf("vec%0d div0_cleared", idx), {31'b0, md_bus.div0}, 32'd0);
    chk($sformatf("vec%0d done_in_run", idx), {31'b0, md_bus.done}, 32'd0);
    n = 0;
    while (md_bus.busy && n < 40) begin
      n++;
      tick();
    end
    chk($sformatf("vec%0d busy_cycles", idx), n, v.exp_cycles);
    chk($sformatf("vec%0d done", idx), {31'b0, md_bus.done}, 32'd1);
    chk($sformatf("vec%0d hi", idx), md_bus.hi, v.exp_hi);
    chk($sformatf("vec%0d lo", idx), md_bus.lo, v.exp_lo);
    chk($sformatf("vec%0d div0", idx), {31'b0, md_bus.div0}, {31'b0, v.exp_div0});
    tick();
    chk($sformatf("vec%0d done_drop", idx), {31'b0, md_bus.done}, 32'd0);
    $display("vec%0d op=%0d a=%h b=%h -> hi=%h lo=%h div0=%0d cycles=%0d",
             idx, v.op, v.a, v.b, md_bus.hi, md_bus.lo, md_bus.div0, n);
  endtask

  initial begin
    int n;
    int done_seen;

    vecs[0]  = '{MD_MULT,  32'hFFFF_FFFD, 32'h0000_0007, 32'h1111_0000, 32'h2222_0000, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 5};
    vecs[1]  = '{MD_MULTU, 32'hFFFF_FFFF, 32'h0000_0002, 32'h1111_0001, 32'h2222_0001, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0, 5};
    vecs[2]  = '{MD_DIVU,  32'd100,       32'd7,         32'h1111_0002, 32'h2222_0002, 32'h0000_0002, 32'h0000_000E, 1'b0, 10};
    vecs[3]  = '{MD_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'h1111_0003, 32'h2222_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 10};
    vecs[4]  = '{MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h1111_0004, 32'h2222_0004, 32'h0000_0000, 32'h8000_0000, 1'b0, 10};
    vecs[5]  = '{MD_DIV,   32'h0000_0005, 32'h0000_0000, 32'h0000_AAAA, 32'h0000_5555, 32'h0000_AAAA, 32'h0000_5555, 1'b1, 10};
    vecs[6]  = '{MD_MULT,  32'h0001_0000, 32'h0001_0000, 32'h1111_0006, 32'h2222_0006, 32'h0000_0001, 32'h0000_0000, 1'b0, 5};
    vecs[7]  = '{MD_DIVU,  32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 32'h0000_0002, 32'h0000_0001, 32'h0000_0002, 1'b1, 10};
    vecs[8]  = '{MD_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 32'h1111_0008, 32'h2222_0008, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0, 10};
    vecs[9]  = '{MD_DIVU,  32'h8000_0000, 32'hFFFF_FFFF, 32'h1111_0009, 32'h2222_0009, 32'h8000_0000, 32'h0000_0000, 1'b0, 10};
    vecs[10] = '{MD_MULT,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1111_000A, 32'h2222_000A, 32'h0000_0000, 32'h0000_0001, 1'b0, 5};
    vecs[11] = '{MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1111_000B, 32'h2222_000B, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 5};

    md_bus.start    = 1'b0;
    md_bus.op       = MD_MULT;
    md_bus.a        = '0;
    md_bus.b        = '0;
    md_bus.mt_we    = 1'b0;
    md_bus.mt_sel   = 1'b0;
    md_bus.md_use_D = 1'b0;
    reset           = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();

    // Reset state.
    chk("rst busy",  {31'b0, md_bus.busy},     32'd0);
    chk("rst done",  {31'b0, md_bus.done},     32'd0);
    chk("rst div0",  {31'b0, md_bus.div0},     32'd0);
    chk("rst stall", {31'b0, md_bus.stall_md}, 32'd0);
    chk("rst hi",    md_bus.hi, 32'd0);
    chk("rst lo",    md_bus.lo, 32'd0);
    $display("reset: busy=%0d hi=%h lo=%h", md_bus.busy, md_bus.hi, md_bus.lo);

    // Table-driven single operations.
    for (int i = 0; i < 12; i++) begin
      run_vec(i, vecs[i]);
    end

    // mthi while idle: visible next cycle, LO untouched.
    mt_write(1'b1, 32'h0000_1234);
    chk("mthi hi", md_bus.hi, 32'h0000_1234);
    chk("mthi lo", md_bus.lo, 32'h0000_0001);
    $display("mthi: hi=%h lo=%h", md_bus.hi, md_bus.lo);

    // Combinational stall in IDLE: start & md_use_D raises it, md_use_D alone does not.
    md_bus.md_use_D = 1'b1;
    #1;
    chk("idle stall nostart", {31'b0, md_bus.stall_md}, 32'd0);
    md_bus.start = 1'b1;
    #1;
    chk("idle stall start", {31'b0, md_bus.stall_md}, 32'd1);
    md_bus.start    = 1'b0;
    md_bus.md_use_D = 1'b0;
    $display("idle stall probe done");
    tick();

    // start together with mt_we in IDLE: start wins, mt write dropped.
    // Then start/mt_we during RUN must not disturb the in-flight op.
    md_bus.op     = MD_MULTU;
    md_bus.a      = 32'd2;
    md_bus.b      = 32'd3;
    md_bus.start  = 1'b1;
    md_bus.mt_we  = 1'b1;
    md_bus.mt_sel = 1'b1;
    tick();
    md_bus.start = 1'b0;
    md_bus.mt_we = 1'b0;
    chk("coll hi_not_written", md_bus.hi, 32'h0000_1234);
    n = 0;
    while (md_bus.busy && n < 40) begin
      n++;
      md_bus.start    = 1'b0;
      md_bus.mt_we    = 1'b0;
      md_bus.md_use_D = 1'b0;
      if (n == 1) begin
        md_bus.md_use_D = 1'b1;
        #1;
        chk("run stall use", {31'b0, md_bus.stall_md}, 32'd1);
        md_bus.md_use_D = 1'b0;
        #1;
        chk("run stall nouse", {31'b0, md_bus.stall_md}, 32'd0);
      end
      if (n == 2) begin
        md_bus.op     = MD_DIV;
        md_bus.a      = 32'd100;
        md_bus.b      = 32'd0;
        md_bus.start  = 1'b1;
        md_bus.mt_we  = 1'b1;
        md_bus.mt_sel = 1'b0;
      end
      tick();
    end
    md_bus.start = 1'b0;
    md_bus.mt_we = 1'b0;
    chk("coll cycles", n, 5);
    chk("coll done", {31'b0, md_bus.done}, 32'd1);
    chk("coll hi",   md_bus.hi, 32'd0);
    chk("coll lo",   md_bus.lo, 32'd6);
    chk("coll div0", {31'b0, md_bus.div0}, 32'd0);
    $display("collision: hi=%h lo=%h cycles=%0d", md_bus.hi, md_bus.lo, n);
    tick();

    // Async reset mid-DIV: immediate clear, no commit, no done pulse.
    mt_write(1'b1, 32'h0000_5A5A);
    md_bus.op    = MD_DIV;
    md_bus.a     = 32'd9;
    md_bus.b     = 32'd2;
    md_bus.start = 1'b1;
    tick();
    md_bus.start = 1'b0;
    tick();
    tick();
    chk("abort busy_before", {31'b0, md_bus.busy}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("abort busy", {31'b0, md_bus.busy}, 32'd0);
    chk("abort hi",   md_bus.hi, 32'd0);
    chk("abort lo",   md_bus.lo, 32'd0);
    tick();
    reset = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 14; i++) begin
      if (md_bus.done || md_bus.busy) done_seen++;
      tick();
    end
    chk("abort no_done", done_seen, 0);
    chk("abort hi_after", md_bus.hi, 32'd0);
    chk("abort lo_after", md_bus.lo, 32'd0);
    $display("abort: busy=%0d hi=%h lo=%h activity=%0d", md_bus.busy, md_bus.hi, md_bus.lo, done_seen);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
